counter32_led_display: RTL and testbench
========================================

Name: counter32_led_display

Overview:
- 32-bit up/down counter for a 10 MHz FPGA board. Two active-low push keys and a 4-bit rotary switch drive it; LEDs show its state.
- Key1 cycles the count mode. Key2 clears the counter.
- Rotary selects which byte of the counter appears on the 8 user LEDs, and the count rate.
- Top-level board block; no bus interface.

Parameters:
- DEBOUNCE_CYCLES, 5000, consecutive stable synchronized samples needed to accept a new key level (0.5 ms at 10 MHz).
- DIV_STEP, 10, ratio between successive rate settings.

Ports:
- i_clk  in  1  system clock, 10 MHz nominal
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_key2_clear  in  1  clear key, active-low, asynchronous to clock
- i_key1_mode  in  1  mode key, active-low, asynchronous to clock
- i_rotary  in  4  rotary switch code, asynchronous
- o_tled  out  4  synchronized rotary value echo
- o_kled  out  4  mode / key status LEDs
- o_led  out  8  selected counter byte

Behaviour:
- Input synchronization:
  - All three inputs pass through 2-flop synchronizers.
  - Each key then passes a debouncer: the debounced level changes only after the synced level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Debounced level resets to 1 (released).
- Press event: single-cycle pulse on a debounced 1->0 transition. Release generates nothing. Holding a key produces exactly one event.
- Mode register, 3 states:
  - UP (reset value) -> DOWN -> STOP -> UP, advanced by each key1 press event.
  - Three presses return to the starting mode.
- Rate select, from synced rotary[3:2]:
  - 00: count enable every cycle.
  - 01: every DIV_STEP cycles.
  - 10: every DIV_STEP^2 cycles.
  - 11: every DIV_STEP^3 cycles.
  - Prescaler counter returns to 0 when the rate field changes, on clear, and on reset.
- Counter (32-bit):
  - On a count enable, mode UP adds 1 and mode DOWN subtracts 1; STOP holds.
  - Wrap-around: 0xFFFFFFFF+1 -> 0x00000000; 0x00000000-1 -> 0xFFFFFFFF.
- Clear: a key2 press event loads the counter with 0 on the next edge. It has priority over a same-cycle count enable and does not change mode.
- Simultaneous key1 event and count enable: the count uses the old mode; the new mode takes effect next cycle.
- Byte select, synced rotary[1:0]: 0 -> counter[7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
- All outputs are registered and update one cycle after their source state:
  - o_led = selected byte.
  - o_tled = synced rotary.
  - o_kled[2:0] = one-hot mode: bit0 UP, bit1 DOWN, bit2 STOP.
  - o_kled[3] = debounced key2 held (1 while pressed).
- Reset values: counter 0, mode UP, prescaler 0, synchronizers and debounced keys 1 (keys) / 0 (rotary).
  - Outputs: o_led 0x00, o_tled 0x0, o_kled 4'b0001.
- Reset mid-operation: all state returns to reset values on the reset edge. A key held through reset produces no event until it is released and pressed again.
- Key-to-effect latency: 2 sync + DEBOUNCE_CYCLES + 1 edge + 1 register cycles.

Optional Feature:
- Macro: WRAP_FLAG_EN.
- When defined:
  - o_kled[3] is a sticky wrap flag, set on any counter wrap in either direction.
  - Cleared by reset or a key2 press event; clear has priority over a same-cycle wrap.
- When undefined: o_kled[3] shows the debounced key2 held level.

Test Plan:
- Reset with keys released and rotary 0 -> o_led 0x00, o_kled 4'b0001, o_tled 0x0; with DEBOUNCE_CYCLES=4, counter reaches 100 and o_led=0x64 after 100 enables.
- Rotary 0 then 1, after 300 cycles at rate 00 -> o_led equals counter[7:0] then counter[15:8]. Verify byte 1 = 0x01 once counter passes 0x100.
- Three key1 presses, each held longer than the debounce time -> o_kled goes 0001 -> 0010 -> 0100 -> 0001; the counter decrements only while in DOWN and holds while in STOP.
- Glitch shorter than DEBOUNCE_CYCLES on key1 -> no mode change. Key held 1000 cycles -> exactly one mode step.
- Mode DOWN at count 0 -> next enable gives 0xFFFFFFFF; rotary 3 -> o_led 0xFF. With WRAP_FLAG_EN, o_kled[3]=1, then cleared by a key2 press.
- Key2 press at counter 0x1234, with a count enable in the same cycle -> counter 0 on the next edge, mode unchanged. Rotary 01 -> exactly one enable per 10 cycles.

Source files
------------

// File: rtl/counter32_led_display.sv
// -----------------------------------------------------------------------------
// counter32_led_display
//
// Board-level 32-bit up/down counter with LED readout.
//   - key1 (active-low) steps the count mode UP -> DOWN -> STOP -> UP.
//   - key2 (active-low) clears the counter to zero.
//   - rotary[3:2] selects the count rate (1, 1/DIV_STEP, 1/DIV_STEP^2,
//     1/DIV_STEP^3 of the clock); rotary[1:0] selects the counter byte
//     shown on the user LEDs.
//
// Ports:
//   i_clk          system clock (10 MHz nominal)
//   i_rst          synchronous active-high reset
//   i_key2_clear   clear key, active-low, asynchronous
//   i_key1_mode    mode key, active-low, asynchronous
//   i_rotary[3:0]  rotary switch code, asynchronous
//   o_tled[3:0]    synchronized rotary echo
//   o_kled[3:0]    [2:0] one-hot mode (UP, DOWN, STOP), [3] key2 status
//   o_led[7:0]     selected counter byte
//
// Build option:
//   WRAP_FLAG_EN   when defined, o_kled[3] is a sticky counter-wrap flag
//                  (cleared by reset or a key2 press); otherwise o_kled[3]
//                  shows the debounced key2 held level.
// -----------------------------------------------------------------------------
module counter32_led_display #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int DIV_STEP        = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key2_clear,
  input  logic       i_key1_mode,
  input  logic [3:0] i_rotary,
  output logic [3:0] o_tled,
  output logic [3:0] o_kled,
  output logic [7:0] o_led
);

  // Debounce counter holds 0 .. DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Prescaler must reach DIV_STEP^3 - 1 for the slowest rate.
  localparam int PERIOD_MAX = DIV_STEP * DIV_STEP * DIV_STEP;
  localparam int PS_W = (PERIOD_MAX > 1) ? $clog2(PERIOD_MAX) : 1;
  localparam logic [PS_W-1:0] TERM_1 = PS_W'(DIV_STEP - 1);
  localparam logic [PS_W-1:0] TERM_2 = PS_W'(DIV_STEP * DIV_STEP - 1);
  localparam logic [PS_W-1:0] TERM_3 = PS_W'(PERIOD_MAX - 1);

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_STOP = 2'd2
  } mode_e;

  // ---------------------------------------------------------------------------
  // Rotary synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] rot_s1_q;
  logic [3:0] rot_s2_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rot_s1_q <= '0;
      rot_s2_q <= '0;
    end else begin
      rot_s1_q <= i_rotary;
      rot_s2_q <= rot_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Post-reset settle: the key synchronizers come out of reset showing
  // "released" for two cycles regardless of the pin. Arming is held off until
  // they reflect the real pin, so a key held through reset cannot be mistaken
  // for a fresh press.
  // ---------------------------------------------------------------------------
  logic [1:0] settle_q;
  logic [1:0] settle_d;
  logic       sync_settled;

  assign sync_settled = (settle_q == 2'd2);
  assign settle_d     = sync_settled ? settle_q : settle_q + 2'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      settle_q <= '0;
    end else begin
      settle_q <= settle_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Key path: sync -> debounce -> press detect. Index 0 = key1, 1 = key2.
  // ---------------------------------------------------------------------------
  logic [1:0] key_raw;
  logic [1:0] key_press;

  assign key_raw = {i_key2_clear, i_key1_mode};

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    logic            key_s1_q;
    logic            key_s2_q;
    logic            deb_q;
    logic            deb_d;
    logic            deb_prev_q;
    logic            armed_q;
    logic            armed_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;

    // The run counter only advances while the synced level disagrees with the
    // accepted level; any agreeing sample restarts the run.
    always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      armed_d  = armed_q;
      if (key_s2_q != deb_q) begin
        if (db_cnt_q == DB_LAST) begin
          deb_d = key_s2_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      // Arm once the key has been seen released with valid synchronizer data.
      if (sync_settled && deb_q && key_s2_q) begin
        armed_d = 1'b1;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        key_s1_q   <= 1'b1;
        key_s2_q   <= 1'b1;
        deb_q      <= 1'b1;
        deb_prev_q <= 1'b1;
        armed_q    <= 1'b0;
        db_cnt_q   <= '0;
      end else begin
        key_s1_q   <= key_raw[gi];
        key_s2_q   <= key_s1_q;
        deb_q      <= deb_d;
        deb_prev_q <= deb_q;
        armed_q    <= armed_d;
        db_cnt_q   <= db_cnt_d;
      end
    end

    // One-cycle pulse on the debounced 1 -> 0 transition only.
    assign key_press[gi] = armed_q & deb_prev_q & ~deb_q;
  end

  logic key1_press;
  logic key2_press;

  assign key1_press = key_press[0];
  assign key2_press = key_press[1];

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  mode_e      mode_q;
  mode_e      mode_d;
  logic [2:0] mode_onehot;

  always_comb begin
    mode_d      = mode_q;
    mode_onehot = 3'b001;
    case (mode_q)
      MODE_DOWN: mode_onehot = 3'b010;
      MODE_STOP: mode_onehot = 3'b100;
      default:   mode_onehot = 3'b001;
    endcase
    if (key1_press) begin
      case (mode_q)
        MODE_UP:   mode_d = MODE_DOWN;
        MODE_DOWN: mode_d = MODE_STOP;
        default:   mode_d = MODE_UP;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Rate prescaler
  // ---------------------------------------------------------------------------
  logic [1:0]      rate_q;
  logic [1:0]      rate_sync;
  logic            rate_change;
  logic [PS_W-1:0] presc_q;
  logic [PS_W-1:0] presc_d;
  logic [PS_W-1:0] presc_term;
  logic            count_en;

  assign rate_sync   = rot_s2_q[3:2];
  assign rate_change = (rate_sync != rate_q);

  always_comb begin
    case (rate_sync)
      2'd1:    presc_term = TERM_1;
      2'd2:    presc_term = TERM_2;
      2'd3:    presc_term = TERM_3;
      default: presc_term = '0;
    endcase
  end

  // A rate change restarts the period without issuing an enable, so the
  // first enable at the new rate comes a full period later.
  always_comb begin
    count_en = 1'b0;
    presc_d  = presc_q + PS_W'(1);
    if (key2_press || rate_change) begin
      presc_d = '0;
    end else if (presc_q >= presc_term) begin
      count_en = 1'b1;
      presc_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter (uses the pre-update mode; clear wins over counting)
  // ---------------------------------------------------------------------------
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (key2_press) begin
      cnt_d = '0;
    end else if (count_en) begin
      case (mode_q)
        MODE_UP:   cnt_d = cnt_q + 32'd1;
        MODE_DOWN: cnt_d = cnt_q - 32'd1;
        default:   cnt_d = cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // o_kled[3] source
  // ---------------------------------------------------------------------------
  logic kled3;

`ifdef WRAP_FLAG_EN
  logic wrap_hit;
  logic wrap_flag_q;
  logic wrap_flag_d;

  assign wrap_hit = count_en &&
                    (((mode_q == MODE_UP) && (&cnt_q)) ||
                     ((mode_q == MODE_DOWN) && (cnt_q == 32'd0)));

  // Clear beats a same-cycle wrap.
  assign wrap_flag_d = key2_press ? 1'b0 : (wrap_flag_q | wrap_hit);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrap_flag_q <= 1'b0;
    end else begin
      wrap_flag_q <= wrap_flag_d;
    end
  end

  assign kled3 = wrap_flag_q;
`else
  assign kled3 = ~g_key[1].deb_q;
`endif

  // ---------------------------------------------------------------------------
  // Core state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      mode_q  <= MODE_UP;
      presc_q <= '0;
      rate_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      rate_q  <= rate_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic [7:0] led_sel;
  logic [7:0] led_q;
  logic [3:0] tled_q;
  logic [3:0] kled_q;

  always_comb begin
    case (rot_s2_q[1:0])
      2'd1:    led_sel = cnt_q[15:8];
      2'd2:    led_sel = cnt_q[23:16];
      2'd3:    led_sel = cnt_q[31:24];
      default: led_sel = cnt_q[7:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      led_q  <= '0;
      tled_q <= '0;
      kled_q <= 4'b0001;
    end else begin
      led_q  <= led_sel;
      tled_q <= rot_s2_q;
      kled_q <= {kled3, mode_onehot};
    end
  end

  assign o_led  = led_q;
  assign o_tled = tled_q;
  assign o_kled = kled_q;

endmodule

// File: tb/tb_counter32_led_display.sv
// -----------------------------------------------------------------------------
// Testbench for counter32_led_display (DEBOUNCE_CYCLES = 4, DIV_STEP = 10).
// A behavioural reference tracks the counter as an integer, the mode as an
// index 0..2, and key effects as events scheduled from the drive times.
// -----------------------------------------------------------------------------
module tb_counter32_led_display;

  localparam int N   = 4;
  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       key1;
  logic       key2;
  logic [3:0] rot;
  logic [3:0] o_tled;
  logic [3:0] o_kled;
  logic [7:0] o_led;

  always #50 clk = ~clk;

  counter32_led_display #(
    .DEBOUNCE_CYCLES(N),
    .DIV_STEP(DIV)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_key2_clear(key2),
    .i_key1_mode(key1),
    .i_rotary(rot),
    .o_tled(o_tled),
    .o_kled(o_kled),
    .o_led(o_led)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  // ---------------- reference model ----------------
  // kind: 0 = mode step, 1 = clear, 2 = key2 becomes held, 3 = key2 released
  typedef struct {
    int at;
    int kind;
  } ev_t;
  ev_t evq[$];

  logic [31:0] m_cnt;
  int          m_mode;
  int          m_since;
  logic [1:0]  m_rate_last;
  logic [3:0]  m_rot_a;   // rotary sampled one edge ago
  logic [3:0]  m_rot_b;   // rotary as seen by the logic (two edges ago)
  bit          m_k2held;
  bit          m_wrap;
  logic [7:0]  m_led;
  logic [3:0]  m_tled;
  logic [3:0]  m_kled;

  always @(posedge clk) begin : model
    int         period;
    bit         en;
    bit         clr;
    bit         adv;
    bit         k3;
    longint     v;
    logic [1:0] rate;
    edge_n++;
    if (rst) begin
      m_cnt = 0; m_mode = 0; m_since = 0; m_rate_last = 0;
      m_rot_a = 0; m_rot_b = 0; m_k2held = 0; m_wrap = 0;
      m_led = 8'h00; m_tled = 4'h0; m_kled = 4'b0001;
      evq.delete();
    end else begin
`ifdef WRAP_FLAG_EN
      k3 = m_wrap;
`else
      k3 = m_k2held;
`endif
      m_led  = m_cnt[8*m_rot_b[1:0] +: 8];
      m_tled = m_rot_b;
      m_kled = {k3, 3'(1 << m_mode)};
      clr = 0;
      adv = 0;
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].at == edge_n) begin
          case (evq[i].kind)
            0: adv = 1;
            1: clr = 1;
            2: m_k2held = 1;
            default: m_k2held = 0;
          endcase
          evq.delete(i);
        end
      end
      rate   = m_rot_b[3:2];
      period = DIV ** int'(rate);
      en = 0;
      if (rate != m_rate_last) begin
        m_rate_last = rate;
        m_since = 0;
      end else if (m_since == period - 1) begin
        en = 1;
        m_since = 0;
      end else begin
        m_since++;
      end
      if (clr) begin
        m_cnt = 0;
        m_since = 0;
        m_wrap = 0;
      end else if (en && m_mode != 2) begin
        v = longint'({32'h0, m_cnt}) + ((m_mode == 0) ? 64'sd1 : -64'sd1);
        if (v < 0 || v > 64'sh0_FFFF_FFFF) m_wrap = 1;
        m_cnt = v[31:0];
      end
      if (adv) m_mode = (m_mode + 1) % 3;
      m_rot_b = m_rot_a;
      m_rot_a = rot;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".led"},  32'(o_led),  32'(m_led));
    chk({tag, ".tled"}, 32'(o_tled), 32'(m_tled));
    chk({tag, ".kled"}, 32'(o_kled), 32'(m_kled));
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; key goes low for 'hold' samples, then 'gap' cycles idle.
  task automatic press_key(input int k, input int hold, input int gap);
    int e0;
    e0 = edge_n + 1;
    if (k == 1) key1 = 1'b0; else key2 = 1'b0;
    if (hold >= N) begin
      evq.push_back('{at: e0 + N + 2, kind: (k == 1) ? 0 : 1});
      if (k == 2) begin
        evq.push_back('{at: e0 + N + 1, kind: 2});
        evq.push_back('{at: e0 + hold + N + 1, kind: 3});
      end
    end
    run(hold);
    check_model("hold");
    if (k == 1) key1 = 1'b1; else key2 = 1'b1;
    run(gap);
  endtask

  // ---------------- stimulus ----------------
  int r;
  int h;

  initial begin
    rst = 1'b1; key1 = 1'b1; key2 = 1'b1; rot = 4'h0;
    run(3);
    rst = 1'b0;

    // Reset state
    chk("rst.led", 32'(o_led), 32'h00);
    chk("rst.tled", 32'(o_tled), 32'h0);
    chk("rst.kled", 32'(o_kled), 32'b0001);
    check_model("rst");

    // 100 enables at full rate
    run(101);
    chk("cnt100.led", 32'(o_led), 32'h64);
    check_model("cnt100");

    // Byte select 1 after the counter passes 0x100
    rot = 4'h1;
    run(300);
    chk("byte1.led", 32'(o_led), 32'h01);
    check_model("byte1");
    rot = 4'h0;
    run(4);

    // Mode cycling
    press_key(1, 8, 12);
    chk("down.mode", 32'(o_kled[2:0]), 32'b010);
    run(10);
    check_model("down");
    press_key(1, 8, 12);
    chk("stop.mode", 32'(o_kled[2:0]), 32'b100);
    run(20);
    check_model("stop");
    press_key(1, 8, 12);
    chk("up.mode", 32'(o_kled[2:0]), 32'b001);
    check_model("up");

    // Glitch shorter than debounce, then a long hold
    press_key(1, N - 2, 12);
    chk("glitch.mode", 32'(o_kled[2:0]), 32'b001);
    check_model("glitch");
    press_key(1, 1000, 12);
    chk("hold1000.mode", 32'(o_kled[2:0]), 32'b010);
    check_model("hold1000");

    // DOWN wrap below zero, slowest rate, top byte shown
    rot = 4'hF;
    run(5);
    press_key(2, 8, 12);
    chk("clr.led", 32'(o_led), 32'h00);
    check_model("clr");
    run(1000);
    chk("wrap.led", 32'(o_led), 32'hFF);
    check_model("wrap");
`ifdef WRAP_FLAG_EN
    chk("wrap.flag", 32'(o_kled[3]), 32'h1);
`endif
    press_key(2, 8, 12);
    chk("clr2.led", 32'(o_led), 32'h00);
    chk("clr2.mode", 32'(o_kled[2:0]), 32'b010);
`ifdef WRAP_FLAG_EN
    chk("clr2.flag", 32'(o_kled[3]), 32'h0);
`endif
    check_model("clr2");

    // Clear against a same-cycle enable at full rate
    rot = 4'h0;
    run(10);
    press_key(2, 8, 12);
    check_model("clr_en");

    // Rate 01: one enable per DIV cycles
    rot = 4'h4;
    for (int i = 0; i < 5; i++) begin
      run(7);
      check_model("rate01");
    end

    // Reset while key1 is held: no event until released and pressed again
    key1 = 1'b0;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(30);
    chk("rsthold.mode", 32'(o_kled[2:0]), 32'b001);
    check_model("rsthold");
    key1 = 1'b1;
    run(12);
    check_model("rsthold_rel");
    press_key(1, 8, 12);
    chk("repress.mode", 32'(o_kled[2:0]), 32'b010);

    // Randomized phase
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 4);
      h = $urandom_range(1, N + 20);
      if (r == 0) begin
        press_key(1, h, 12);
      end else if (r == 1) begin
        press_key(2, h, 12);
      end else begin
        rot = 4'($urandom_range(0, 15));
        run($urandom_range(1, 60));
      end
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
